// File: rtl/port_wr_sram_writer_if.sv
// Bundled stream, page-allocator, SRAM, linked-list and descriptor signals of the
// port write back-end. The slave modport is the writer; master is its environment.
interface port_wr_sram_writer_if #(
   parameter int unsigned PAGE_W = 11
) ();
   logic              xfer_data_vld;
   logic [15:0]       xfer_data;
   logic              end_of_packet;

   logic              page_req;
   logic              page_gnt;
   logic [PAGE_W-1:0] page_addr;

   logic              sram_wr_en;
   logic [PAGE_W+2:0] sram_wr_addr;
   logic [15:0]       sram_wr_data;

   logic              link_wr_en;
   logic [PAGE_W-1:0] link_addr;
   logic [PAGE_W-1:0] link_data;

   logic              desc_vld;
   logic              desc_rdy;
   logic [3:0]        desc_dest;
   logic [8:0]        desc_len;
   logic [PAGE_W-1:0] desc_head;
   logic [PAGE_W-1:0] desc_tail;
   logic              len_err;
   logic              ovf_err;

   modport slave (
      input  xfer_data_vld, xfer_data, end_of_packet,
      input  page_gnt, page_addr,
      input  desc_rdy,
      output page_req,
      output sram_wr_en, sram_wr_addr, sram_wr_data,
      output link_wr_en, link_addr, link_data,
      output desc_vld, desc_dest, desc_len, desc_head, desc_tail,
      output len_err, ovf_err
   );

   modport master (
      output xfer_data_vld, xfer_data, end_of_packet,
      output page_gnt, page_addr,
      output desc_rdy,
      input  page_req,
      input  sram_wr_en, sram_wr_addr, sram_wr_data,
      input  link_wr_en, link_addr, link_data,
      input  desc_vld, desc_dest, desc_len, desc_head, desc_tail,
      input  len_err, ovf_err
   );
endinterface

// File: rtl/port_wr_sram_writer.sv
// Port write back-end: buffers the half-word stream, packs it into 8-half-word SRAM
// pages, links the pages of a packet and issues one descriptor per packet.
module port_wr_sram_writer #(
   parameter int unsigned PAGE_W     = 11,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input logic                  clk,
   input logic                  rst,
   port_wr_sram_writer_if.slave bus
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [0:0] {StIdle, StBody} state_e;

   // Holding FIFO
   logic [16:0]     mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] fill_q, fill_d;
   logic            full, empty, push, pop;
   logic [15:0]     head_data;
   logic            head_eop;

   // Page and packet state
   logic              pf_vld_q, pf_vld_d;
   logic [PAGE_W-1:0] pf_page_q, pf_page_d;
   logic [PAGE_W-1:0] cur_page_q, cur_page_d;
   logic [2:0]        offset_q, offset_d;
   state_e            state_q, state_d;
   logic [3:0]        dest_q, dest_d;
   logic [8:0]        hdr_len_q, hdr_len_d;
   logic [PAGE_W-1:0] head_pg_q, head_pg_d;
   logic [8:0]        cnt_q, cnt_d;

   // Registered outputs
   logic              sram_wr_en_q, sram_wr_en_d;
   logic [PAGE_W+2:0] sram_wr_addr_q, sram_wr_addr_d;
   logic [15:0]       sram_wr_data_q, sram_wr_data_d;
   logic              link_wr_en_q, link_wr_en_d;
   logic [PAGE_W-1:0] link_addr_q, link_addr_d;
   logic [PAGE_W-1:0] link_data_q, link_data_d;
   logic              desc_vld_q, desc_vld_d;
   logic [3:0]        desc_dest_q, desc_dest_d;
   logic [8:0]        desc_len_q, desc_len_d;
   logic [PAGE_W-1:0] desc_head_q, desc_head_d;
   logic [PAGE_W-1:0] desc_tail_q, desc_tail_d;
   logic              len_err_q, len_err_d;
   logic              ovf_err_q, ovf_err_d;

   // Combinational helpers
   logic [PAGE_W-1:0] page_used;
   logic [8:0]        cnt_inc;
   logic [8:0]        len_now;
   logic [8:0]        hdr_now;
   logic [3:0]        dest_now;
   logic [PAGE_W-1:0] head_now;
   logic              eop_stall;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign full      = (fill_q == CntW'(FIFO_DEPTH));
   assign empty     = (fill_q == '0);
   assign head_data = mem_q[rd_ptr_q][15:0];
   assign head_eop  = mem_q[rd_ptr_q][16];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {bus.end_of_packet, bus.xfer_data};
      end
   end

   always_comb begin
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      pf_vld_d       = pf_vld_q;
      pf_page_d      = pf_page_q;
      cur_page_d     = cur_page_q;
      offset_d       = offset_q;
      state_d        = state_q;
      dest_d         = dest_q;
      hdr_len_d      = hdr_len_q;
      head_pg_d      = head_pg_q;
      cnt_d          = cnt_q;
      sram_wr_en_d   = 1'b0;
      sram_wr_addr_d = sram_wr_addr_q;
      sram_wr_data_d = sram_wr_data_q;
      link_wr_en_d   = 1'b0;
      link_addr_d    = link_addr_q;
      link_data_d    = link_data_q;
      desc_vld_d     = desc_vld_q;
      desc_dest_d    = desc_dest_q;
      desc_len_d     = desc_len_q;
      desc_head_d    = desc_head_q;
      desc_tail_d    = desc_tail_q;
      len_err_d      = len_err_q;

      page_used = (offset_q == 3'd0) ? pf_page_q : cur_page_q;
      cnt_inc   = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + 9'd1;
      len_now   = cnt_inc;
      hdr_now   = hdr_len_q;
      dest_now  = dest_q;
      head_now  = head_pg_q;

      // A finished packet waits in the FIFO while the previous descriptor is pending.
      eop_stall = head_eop & desc_vld_q & ~bus.desc_rdy;
      pop       = ~empty & ((offset_q != 3'd0) | pf_vld_q) & ~eop_stall;
      push      = bus.xfer_data_vld & (~full | pop);
      ovf_err_d = ovf_err_q | (bus.xfer_data_vld & full & ~pop);
      fill_d    = fill_q + CntW'(push) - CntW'(pop);

      if (push) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end

      if (bus.page_gnt && !pf_vld_q) begin
         pf_page_d = bus.page_addr;
         pf_vld_d  = 1'b1;
      end

      if (desc_vld_q && bus.desc_rdy) begin
         desc_vld_d = 1'b0;
      end

      if (pop) begin
         rd_ptr_d       = ptr_inc(rd_ptr_q);
         sram_wr_en_d   = 1'b1;
         sram_wr_addr_d = {page_used, offset_q};
         sram_wr_data_d = head_data;
         offset_d       = offset_q + 3'd1;

         if (offset_q == 3'd0) begin
            cur_page_d = pf_page_q;
            pf_vld_d   = 1'b0;
            if (state_q == StBody) begin
               link_wr_en_d = 1'b1;
               link_addr_d  = cur_page_q;
               link_data_d  = pf_page_q;
            end
         end

         if (state_q == StIdle) begin
            dest_now  = head_data[3:0];
            hdr_now   = head_data[15:7];
            head_now  = page_used;
            len_now   = 9'd1;
            dest_d    = dest_now;
            hdr_len_d = hdr_now;
            head_pg_d = head_now;
            state_d   = StBody;
         end
         cnt_d = len_now;

         if (head_eop) begin
            desc_vld_d  = 1'b1;
            desc_dest_d = dest_now;
            desc_len_d  = len_now;
            desc_head_d = head_now;
            desc_tail_d = page_used;
            len_err_d   = (len_now != hdr_now);
            offset_d    = 3'd0;
            state_d     = StIdle;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         fill_q         <= '0;
         pf_vld_q       <= 1'b0;
         pf_page_q      <= '0;
         cur_page_q     <= '0;
         offset_q       <= 3'd0;
         state_q        <= StIdle;
         dest_q         <= '0;
         hdr_len_q      <= '0;
         head_pg_q      <= '0;
         cnt_q          <= '0;
         sram_wr_en_q   <= 1'b0;
         sram_wr_addr_q <= '0;
         sram_wr_data_q <= '0;
         link_wr_en_q   <= 1'b0;
         link_addr_q    <= '0;
         link_data_q    <= '0;
         desc_vld_q     <= 1'b0;
         desc_dest_q    <= '0;
         desc_len_q     <= '0;
         desc_head_q    <= '0;
         desc_tail_q    <= '0;
         len_err_q      <= 1'b0;
         ovf_err_q      <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         fill_q         <= fill_d;
         pf_vld_q       <= pf_vld_d;
         pf_page_q      <= pf_page_d;
         cur_page_q     <= cur_page_d;
         offset_q       <= offset_d;
         state_q        <= state_d;
         dest_q         <= dest_d;
         hdr_len_q      <= hdr_len_d;
         head_pg_q      <= head_pg_d;
         cnt_q          <= cnt_d;
         sram_wr_en_q   <= sram_wr_en_d;
         sram_wr_addr_q <= sram_wr_addr_d;
         sram_wr_data_q <= sram_wr_data_d;
         link_wr_en_q   <= link_wr_en_d;
         link_addr_q    <= link_addr_d;
         link_data_q    <= link_data_d;
         desc_vld_q     <= desc_vld_d;
         desc_dest_q    <= desc_dest_d;
         desc_len_q     <= desc_len_d;
         desc_head_q    <= desc_head_d;
         desc_tail_q    <= desc_tail_d;
         len_err_q      <= len_err_d;
         ovf_err_q      <= ovf_err_d;
      end
   end

   // Request is masked during reset so every output reads 0 while rst is held.
   assign bus.page_req     = ~pf_vld_q & ~rst;
   assign bus.sram_wr_en   = sram_wr_en_q;
   assign bus.sram_wr_addr = sram_wr_addr_q;
   assign bus.sram_wr_data = sram_wr_data_q;
   assign bus.link_wr_en   = link_wr_en_q;
   assign bus.link_addr    = link_addr_q;
   assign bus.link_data    = link_data_q;
   assign bus.desc_vld     = desc_vld_q;
   assign bus.desc_dest    = desc_dest_q;
   assign bus.desc_len     = desc_len_q;
   assign bus.desc_head    = desc_head_q;
   assign bus.desc_tail    = desc_tail_q;
   assign bus.len_err      = len_err_q;
   assign bus.ovf_err      = ovf_err_q;

endmodule

// File: tb/tb_port_wr_sram_writer.sv
// Directed bench: table of whole-packet vectors plus hand-written sequences for
// overflow, descriptor back-pressure and asynchronous reset mid-packet.
module tb_port_wr_sram_writer;

   localparam int unsigned PAGE_W = 11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   port_wr_sram_writer_if #(.PAGE_W(PAGE_W)) bus ();

   port_wr_sram_writer #(
      .PAGE_W     (PAGE_W),
      .FIFO_DEPTH (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int          n;
      logic [15:0] hdr;
      int          gnt_dly;
      logic [10:0] pg0, pg1, pg2;
      logic [3:0]  e_dest;
      int          e_len;
      logic [10:0] e_head, e_tail;
      logic        e_lerr;
      int          e_links;
      logic [13:0] e_last;
   } vec_t;

   int n_total = 0;
   int n_pass  = 0;

   logic [10:0] page_list [16];
   int          pg_idx;
   logic        gnt_en;

   logic [13:0] wa_q [$];
   logic [15:0] wd_q [$];
   logic [10:0] la_q [$];
   logic [10:0] ld_q [$];
   int          n_desc;
   logic [3:0]  d_dest;
   logic [8:0]  d_len;
   logic [10:0] d_head, d_tail;
   logic        d_lerr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
   endtask

   function automatic int outputs_nonzero();
      int f = 0;
      if (bus.page_req)           f |= 1 << 0;
      if (bus.sram_wr_en)         f |= 1 << 1;
      if (bus.sram_wr_addr != 0)  f |= 1 << 2;
      if (bus.sram_wr_data != 0)  f |= 1 << 3;
      if (bus.link_wr_en)         f |= 1 << 4;
      if (bus.link_addr != 0)     f |= 1 << 5;
      if (bus.link_data != 0)     f |= 1 << 6;
      if (bus.desc_vld)           f |= 1 << 7;
      if (bus.desc_dest != 0)     f |= 1 << 8;
      if (bus.desc_len != 0)      f |= 1 << 9;
      if (bus.desc_head != 0)     f |= 1 << 10;
      if (bus.desc_tail != 0)     f |= 1 << 11;
      if (bus.len_err)            f |= 1 << 12;
      if (bus.ovf_err)            f |= 1 << 13;
      return f;
   endfunction

   function automatic logic [15:0] beat_data(input int i, input logic [15:0] hdr);
      return (i == 0) ? hdr : (16'hC000 | 16'(i));
   endfunction

   // Drives one cycle at the falling edge, acts as page allocator, records outputs
   // at the next falling edge.
   task automatic tick(input logic v, input logic [15:0] d, input logic e);
      bus.xfer_data_vld = v;
      bus.xfer_data     = d;
      bus.end_of_packet = e;
      bus.page_gnt      = gnt_en & bus.page_req;
      bus.page_addr     = page_list[pg_idx % 16];
      @(posedge clk);
      if (bus.page_gnt) pg_idx++;
      @(negedge clk);
      if (bus.sram_wr_en) begin
         wa_q.push_back(bus.sram_wr_addr);
         wd_q.push_back(bus.sram_wr_data);
      end
      if (bus.link_wr_en) begin
         la_q.push_back(bus.link_addr);
         ld_q.push_back(bus.link_data);
      end
      if (bus.desc_vld) begin
         n_desc++;
         d_dest = bus.desc_dest;
         d_len  = bus.desc_len;
         d_head = bus.desc_head;
         d_tail = bus.desc_tail;
         d_lerr = bus.len_err;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst               = 1'b1;
      bus.xfer_data_vld = 1'b0;
      bus.xfer_data     = '0;
      bus.end_of_packet = 1'b0;
      bus.page_gnt      = 1'b0;
      bus.page_addr     = '0;
      bus.desc_rdy      = 1'b1;
      gnt_en            = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_outputs_zero", outputs_nonzero(), 0);
      rst    = 1'b0;
      pg_idx = 0;
      n_desc = 0;
      wa_q.delete(); wd_q.delete(); la_q.delete(); ld_q.delete();
      for (int k = 0; k < 16; k++) page_list[k] = 11'h600 + 11'(k);
      #1;
      chk("page_req_after_rst", bus.page_req, 1);
   endtask

   task automatic run_pkt(input vec_t v);
      int after = -1;
      page_list[0] = v.pg0;
      page_list[1] = v.pg1;
      page_list[2] = v.pg2;
      for (int c = 0; c < 300; c++) begin
         gnt_en = (c >= v.gnt_dly);
         if (c < v.n) tick(1'b1, beat_data(c, v.hdr), c == v.n - 1);
         else         tick(1'b0, 16'h0, 1'b0);
         if (n_desc > 0 && after < 0) after = c;
         if (after >= 0 && c >= after + 3) break;
      end
   endtask

   task automatic check_pkt(input string tag, input vec_t v);
      int bad = 0;
      int nw  = wa_q.size();
      chk({tag, "_desc_cnt"}, n_desc, 1);
      chk({tag, "_dest"}, d_dest, v.e_dest);
      chk({tag, "_len"}, d_len, v.e_len);
      chk({tag, "_head"}, d_head, v.e_head);
      chk({tag, "_tail"}, d_tail, v.e_tail);
      chk({tag, "_len_err"}, d_lerr, v.e_lerr);
      chk({tag, "_wr_cnt"}, nw, v.n);
      chk({tag, "_last_addr"}, (nw > 0) ? wa_q[nw-1] : 14'h0, v.e_last);
      for (int i = 0; i < nw && i < v.n; i++) begin
         if (wa_q[i] !== {page_list[i/8], 3'(i % 8)}) bad++;
         if (wd_q[i] !== beat_data(i, v.hdr)) bad++;
      end
      chk({tag, "_wr_seq_errs"}, bad, 0);
      chk({tag, "_link_cnt"}, la_q.size(), v.e_links);
      bad = 0;
      for (int i = 0; i < la_q.size(); i++) begin
         if (la_q[i] !== page_list[i] || ld_q[i] !== page_list[i+1]) bad++;
      end
      chk({tag, "_link_seq_errs"}, bad, 0);
      chk({tag, "_ovf"}, bus.ovf_err, 0);
   endtask

   vec_t vecs [5];
   vec_t mid_v;

   initial begin
      //         n   hdr      dly pg0     pg1     pg2     dest len head    tail    lerr lnk last
      vecs[0] = '{8,  16'h0405, 0, 11'h010, 11'h011, 11'h012, 4'h5, 8,  11'h010, 11'h010, 0, 0, 14'h0087};
      vecs[1] = '{9,  16'h0483, 0, 11'h010, 11'h022, 11'h033, 4'h3, 9,  11'h010, 11'h022, 0, 1, 14'h0110};
      vecs[2] = '{12, 16'h050A, 0, 11'h005, 11'h3FF, 11'h006, 4'hA, 12, 11'h005, 11'h3FF, 1, 1, 14'h1FFB};
      vecs[3] = '{1,  16'h008F, 0, 11'h7FF, 11'h001, 11'h002, 4'hF, 1,  11'h7FF, 11'h7FF, 0, 0, 14'h3FF8};
      vecs[4] = '{20, 16'h0A02, 10, 11'h100, 11'h101, 11'h102, 4'h2, 20, 11'h100, 11'h102, 0, 2, 14'h0813};
      mid_v   = '{3,  16'h0187, 0, 11'h050, 11'h051, 11'h052, 4'h7, 3,  11'h050, 11'h050, 0, 0, 14'h0282};

      for (int t = 0; t < 5; t++) begin
         do_reset();
         run_pkt(vecs[t]);
         check_pkt($sformatf("vec%0d", t), vecs[t]);
      end

      // Allocator withheld for 20 cycles: beat 17 finds the FIFO full.
      do_reset();
      for (int k = 0; k < 16; k++) page_list[k] = 11'h100 + 11'(k);
      for (int c = 0; c < 20; c++) begin
         tick(1'b1, beat_data(c, 16'h0A02), c == 19);
         if (c == 15) chk("ovf_before_beat17", bus.ovf_err, 0);
         if (c == 16) chk("ovf_after_beat17", bus.ovf_err, 1);
      end
      gnt_en = 1'b1;
      for (int c = 0; c < 30; c++) tick(1'b0, 16'h0, 1'b0);
      begin
         int bad = 0;
         chk("ovf_wr_cnt", wa_q.size(), 16);
         for (int i = 0; i < wa_q.size() && i < 16; i++) begin
            if (wa_q[i] !== {page_list[i/8], 3'(i % 8)} || wd_q[i] !== beat_data(i, 16'h0A02))
               bad++;
         end
         chk("ovf_wr_seq_errs", bad, 0);
      end
      chk("ovf_no_desc", n_desc, 0);
      chk("ovf_sticky", bus.ovf_err, 1);

      // Two 2-beat packets with the descriptor stalled for 6 cycles.
      do_reset();
      page_list[0] = 11'h010; page_list[1] = 11'h020; page_list[2] = 11'h030;
      gnt_en       = 1'b1;
      bus.desc_rdy = 1'b0;
      for (int c = 0; c < 8; c++) begin
         bus.desc_rdy = (c >= 6);
         case (c)
            0: tick(1'b1, 16'h0101, 1'b0);
            1: tick(1'b1, 16'hC001, 1'b1);
            2: tick(1'b1, 16'h0102, 1'b0);
            3: tick(1'b1, 16'hC001, 1'b1);
            default: tick(1'b0, 16'h0, 1'b0);
         endcase
         if (c >= 2 && c <= 5)
            chk($sformatf("stall_desc1_c%0d", c),
                {bus.desc_vld, bus.desc_dest, bus.desc_len, bus.desc_head, bus.desc_tail},
                {1'b1, 4'd1, 9'd2, 11'h010, 11'h010});
         if (c == 5) begin
            chk("stall_eop2_held", wa_q.size(), 3);
            chk("stall_pkt2_new_page", (wa_q.size() > 2) ? wa_q[2] : 14'h0, 14'h0100);
         end
         if (c == 6) begin
            chk("stall_desc2",
                {bus.desc_vld, bus.desc_dest, bus.desc_len, bus.desc_head, bus.desc_tail},
                {1'b1, 4'd2, 9'd2, 11'h020, 11'h020});
            chk("stall_desc2_len_err", bus.len_err, 0);
            chk("stall_eop2_addr", {bus.sram_wr_en, bus.sram_wr_addr}, {1'b1, 14'h0101});
         end
         if (c == 7) chk("stall_desc2_cleared", bus.desc_vld, 0);
      end

      // Asynchronous reset in the middle of a packet, then a clean packet.
      do_reset();
      page_list[0] = 11'h040; page_list[1] = 11'h041;
      gnt_en = 1'b1;
      for (int c = 0; c < 5; c++) tick(1'b1, beat_data(c, 16'h0A00), 1'b0);
      chk("mid_wr_active", bus.sram_wr_en, 1);
      #2 rst = 1'b1;
      #1 chk("async_rst_outputs_zero", outputs_nonzero(), 0);
      do_reset();
      run_pkt(mid_v);
      check_pkt("after_rst", mid_v);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
